gpio_seq_ctrl: RTL and testbench

GPIO_SEQ_CTRL -- requirements
Module: gpio_seq_ctrl

---
 rtl/gpio_seq_ctrl_pkg.sv | 28 ++
 rtl/gpio_seq_mem.sv | 27 ++
 rtl/gpio_seq_ctrl.sv | 121 ++++++++++++
 tb/tb_gpio_seq_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_seq_ctrl_pkg.sv
// Shared types for the GPIO step sequencer: FSM state encoding, step record and the masked-write helper.
package gpio_seq_ctrl_pkg;

  localparam int GPIO_W         = 32;
  // Widest hold delay a step can carry; the DLY_W parameter must not exceed it.
  localparam int STEP_DLY_MAX_W = 32;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_HOLD = ST_HOLD
  } state_e;

  typedef struct packed {
    logic [GPIO_W-1:0]         mask;
    logic [GPIO_W-1:0]         value;
    logic [STEP_DLY_MAX_W-1:0] delay;
  } step_t;

  function automatic logic [GPIO_W-1:0] apply_step(input logic [GPIO_W-1:0] cur, input step_t s);
    return (cur & ~s.mask) | (s.value & s.mask);
  endfunction

endpackage

// File: rtl/gpio_seq_mem.sv
// Step list storage: one write port, one combinational read port.
module gpio_seq_mem
  import gpio_seq_ctrl_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                       sys_clk,
  input  logic                       we,
  input  logic [$clog2(DEPTH)-1:0]   waddr,
  input  step_t                      wdata,
  input  logic [$clog2(DEPTH)-1:0]   raddr,
  output step_t                      rdata
);

  step_t mem [DEPTH];

  // NOTE: the array has no reset; entries are only read after being written, and leaving
  // storage unreset keeps it mappable onto plain register files or LUT RAM.
  always_ff @(posedge sys_clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/gpio_seq_ctrl.sv
// GPIO step sequencer: plays a loaded list of masked writes onto gpio_out with a per-step hold.
// Define GPIO_SEQ_LOOP_EN to add the loop input, which restarts the list instead of finishing.
module gpio_seq_ctrl
  import gpio_seq_ctrl_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int DLY_W = 16
) (
  input  logic                   sys_clk,
  input  logic                   rst,
`ifdef GPIO_SEQ_LOOP_EN
  input  logic                   loop,
`endif
  input  logic                   step_valid,
  output logic                   step_ready,
  input  logic [GPIO_W-1:0]      step_mask,
  input  logic [GPIO_W-1:0]      step_value,
  input  logic [DLY_W-1:0]       step_delay,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   clear,
  input  logic [GPIO_W-1:0]      gpio_base,
  output logic [GPIO_W-1:0]      gpio_out,
  output logic                   busy,
  output logic                   done,
  output logic [$clog2(DEPTH):0] step_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  state_e                    state;
  logic [CW-1:0]             idx;
  logic [STEP_DLY_MAX_W-1:0] hold_cnt;
  logic [AW-1:0]             rd_addr;
  step_t                     wr_step;
  step_t                     rd_step;
  logic                      accept;
  logic                      at_end;
  logic                      advance;
  logic                      restart;
  logic                      loop_en;

`ifdef GPIO_SEQ_LOOP_EN
  assign loop_en = loop;
`else
  assign loop_en = 1'b0;
`endif

  assign step_ready = (state == S_IDLE) && (step_count < CW'(DEPTH));
  assign accept     = step_valid && step_ready && !clear;
  assign busy       = (state != S_IDLE);
  assign at_end     = (idx == step_count);
  // RUN only exists to finish an empty list; HOLD advances once its counter has drained.
  assign advance    = (state == S_RUN) || ((state == S_HOLD) && (hold_cnt == '0));
  assign restart    = loop_en && (state == S_HOLD);
  assign done       = !abort && advance && at_end && !restart;
  assign rd_addr    = ((state == S_IDLE) || at_end) ? '0 : idx[AW-1:0];
  assign wr_step    = '{mask: step_mask, value: step_value, delay: STEP_DLY_MAX_W'(step_delay)};

  gpio_seq_mem #(.DEPTH(DEPTH)) u_mem (
    .sys_clk (sys_clk),
    .we      (accept),
    .waddr   (step_count[AW-1:0]),
    .wdata   (wr_step),
    .raddr   (rd_addr),
    .rdata   (rd_step)
  );

  // NOTE: every register here uses non-blocking assignment so all of them update from the
  // same pre-edge values; a blocking write would leak into later reads within this block.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state      <= S_IDLE;
      gpio_out   <= '0;
      step_count <= '0;
      idx        <= '0;
      hold_cnt   <= '0;
    end else begin
      if (accept) begin
        step_count <= step_count + CW'(1);
      end
      case (state)
        S_IDLE: begin
          gpio_out <= gpio_base;
          idx      <= '0;
          if (!abort && start) begin
            if (step_count == '0) begin
              state <= S_RUN;
            end else begin
              gpio_out <= apply_step(gpio_out, rd_step);
              hold_cnt <= rd_step.delay;
              idx      <= CW'(1);
              state    <= S_HOLD;
            end
          end else if (!abort && clear) begin
            step_count <= '0;
          end
        end
        default: begin
          if (abort) begin
            state <= S_IDLE;
          end else if (advance) begin
            if (!at_end || restart) begin
              gpio_out <= apply_step(gpio_out, rd_step);
              hold_cnt <= rd_step.delay;
              idx      <= CW'(rd_addr) + CW'(1);
              state    <= S_HOLD;
            end else begin
              gpio_out <= gpio_base;
              state    <= S_IDLE;
            end
          end else begin
            hold_cnt <= hold_cnt - STEP_DLY_MAX_W'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gpio_seq_ctrl.sv
// Directed bench for gpio_seq_ctrl: expected per-cycle outputs are queued when a run starts and popped as it plays.
// The loop scenario is included when GPIO_SEQ_LOOP_EN is defined.
module tb_gpio_seq_ctrl;

  localparam int DEPTH = 8;
  localparam int DLY_W = 16;

  typedef struct packed {
    logic [31:0] gpio;
    logic        done;
    logic        busy;
    logic        chk_busy;
  } exp_t;

  logic              sys_clk = 1'b0;
  logic              rst;
`ifdef GPIO_SEQ_LOOP_EN
  logic              loop;
`endif
  logic              step_valid;
  logic              step_ready;
  logic [31:0]       step_mask;
  logic [31:0]       step_value;
  logic [DLY_W-1:0]  step_delay;
  logic              start;
  logic              abort;
  logic              clear;
  logic [31:0]       gpio_base;
  logic [31:0]       gpio_out;
  logic              busy;
  logic              done;
  logic [3:0]        step_count;

  int          total = 0;
  int          bad   = 0;
  exp_t        sb[$];
  logic [31:0] cur;
  logic [31:0] m_t [DEPTH];
  logic [31:0] v_t [DEPTH];
  int          d_t [DEPTH];

  always #5 sys_clk = ~sys_clk;

  gpio_seq_ctrl #(.DEPTH(DEPTH), .DLY_W(DLY_W)) dut (
    .sys_clk    (sys_clk),
    .rst        (rst),
`ifdef GPIO_SEQ_LOOP_EN
    .loop       (loop),
`endif
    .step_valid (step_valid),
    .step_ready (step_ready),
    .step_mask  (step_mask),
    .step_value (step_value),
    .step_delay (step_delay),
    .start      (start),
    .abort      (abort),
    .clear      (clear),
    .gpio_base  (gpio_base),
    .gpio_out   (gpio_out),
    .busy       (busy),
    .done       (done),
    .step_count (step_count)
  );

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [31:0] m, input logic [31:0] v, input int d);
    step_mask  = m;
    step_value = v;
    step_delay = DLY_W'(d);
    step_valid = 1'b1;
    check("load_ready", {31'b0, step_ready}, 32'd1);
    tick();
    step_valid = 1'b0;
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() != 0) begin
      e = sb.pop_front();
      check("sb_gpio", gpio_out, e.gpio);
      check("sb_done", {31'b0, done}, {31'b0, e.done});
      if (e.chk_busy) check("sb_busy", {31'b0, busy}, {31'b0, e.busy});
      tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; step_valid = 1'b0; step_mask = '0; step_value = '0; step_delay = '0;
    start = 1'b0; abort = 1'b0; clear = 1'b0; gpio_base = 32'hFFFF_FFFF;
`ifdef GPIO_SEQ_LOOP_EN
    loop = 1'b0;
`endif
    repeat (3) tick();
    check("rst_gpio",  gpio_out, 32'h0);
    check("rst_count", {28'b0, step_count}, 32'd0);
    check("rst_busy",  {31'b0, busy}, 32'd0);
    check("rst_done",  {31'b0, done}, 32'd0);
    rst = 1'b0;
    gpio_base = 32'h0;
    tick();

    // Three-step list, base 0.
    load(32'hFF,  32'h01,  0);
    load(32'hFF,  32'h02,  2);
    load(32'hF00, 32'h300, 0);
    check("count3", {28'b0, step_count}, 32'd3);
    start = 1'b1;
    sb.push_back(exp_t'{32'h001, 1'b0, 1'b1, 1'b1});
    sb.push_back(exp_t'{32'h002, 1'b0, 1'b1, 1'b1});
    sb.push_back(exp_t'{32'h002, 1'b0, 1'b1, 1'b1});
    sb.push_back(exp_t'{32'h002, 1'b0, 1'b1, 1'b1});
    sb.push_back(exp_t'{32'h302, 1'b1, 1'b1, 1'b1});
    sb.push_back(exp_t'{32'h000, 1'b0, 1'b0, 1'b1});
    tick();
    start = 1'b0;
    drain();

    // Same list replayed over a non-zero base.
    gpio_base = 32'hF0F0;
    repeat (2) tick();
    start = 1'b1;
    sb.push_back(exp_t'{32'hF001, 1'b0, 1'b1, 1'b1});
    sb.push_back(exp_t'{32'hF002, 1'b0, 1'b1, 1'b1});
    sb.push_back(exp_t'{32'hF002, 1'b0, 1'b1, 1'b1});
    sb.push_back(exp_t'{32'hF002, 1'b0, 1'b1, 1'b1});
    sb.push_back(exp_t'{32'hF302, 1'b1, 1'b1, 1'b1});
    sb.push_back(exp_t'{32'hF0F0, 1'b0, 1'b0, 1'b1});
    tick();
    start = 1'b0;
    drain();

    // Fill the list, then offer a ninth step.
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clear_idle", {28'b0, step_count}, 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      m_t[i] = 32'hF << (4 * i);
      v_t[i] = (i + 1) << (4 * i);
      d_t[i] = i % 2;
      load(m_t[i], v_t[i], d_t[i]);
    end
    check("full_ready", {31'b0, step_ready}, 32'd0);
    check("full_count", {28'b0, step_count}, 32'd8);
    step_mask = 32'hFFFF_FFFF; step_value = 32'hDEAD_BEEF; step_delay = 16'd5; step_valid = 1'b1;
    tick();
    step_valid = 1'b0;
    check("ninth_count", {28'b0, step_count}, 32'd8);

    // Play the full list; the expected trace comes from a masked-write model of the list.
    gpio_base = 32'h1234_5678;
    repeat (2) tick();
    cur = gpio_base;
    for (int i = 0; i < DEPTH; i++) begin
      cur = (cur & ~m_t[i]) | (v_t[i] & m_t[i]);
      for (int k = 0; k <= d_t[i]; k++)
        sb.push_back(exp_t'{cur, (i == DEPTH - 1) && (k == d_t[i]), 1'b1, 1'b1});
    end
    sb.push_back(exp_t'{32'h1234_5678, 1'b0, 1'b0, 1'b1});
    start = 1'b1;
    tick();
    start = 1'b0;
    drain();

    // Start together with abort in IDLE does nothing.
    start = 1'b1; abort = 1'b1;
    sb.push_back(exp_t'{32'h1234_5678, 1'b0, 1'b0, 1'b1});
    sb.push_back(exp_t'{32'h1234_5678, 1'b0, 1'b0, 1'b1});
    tick();
    start = 1'b0; abort = 1'b0;
    drain();
    check("start_abort_count", {28'b0, step_count}, 32'd8);

    // Long hold: clear while busy is ignored, abort ends the run without done.
    clear = 1'b1;
    tick();
    clear = 1'b0;
    load(32'h0000_FFFF, 32'h0000_ABCD, 100);
    load(32'hFFFF_0000, 32'h1234_0000, 0);
    gpio_base = 32'h5555_0000;
    repeat (2) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("hold_gpio", gpio_out, 32'h5555_ABCD);
    repeat (3) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("busy_clear_count", {28'b0, step_count}, 32'd2);
    check("busy_clear_busy",  {31'b0, busy}, 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_done", {31'b0, done}, 32'd0);
    tick();
    check("abort_gpio", gpio_out, 32'h5555_0000);
    check("abort_done2", {31'b0, done}, 32'd0);

    // Clear in IDLE, then start on an empty list.
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clear_count", {28'b0, step_count}, 32'd0);
    start = 1'b1;
    sb.push_back(exp_t'{32'h5555_0000, 1'b1, 1'b1, 1'b0});
    sb.push_back(exp_t'{32'h5555_0000, 1'b0, 1'b0, 1'b1});
    tick();
    start = 1'b0;
    drain();

`ifdef GPIO_SEQ_LOOP_EN
    // Two-step list looping three times, then finishing once loop drops.
    load(32'hFF, 32'h11, 0);
    load(32'hFF, 32'h22, 1);
    gpio_base = 32'h0;
    repeat (2) tick();
    loop = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int r = 0; r < 4; r++) begin
      if (r == 3) loop = 1'b0;
      check("loop_s0", gpio_out, 32'h11);
      check("loop_d0", {31'b0, done}, 32'd0);
      tick();
      check("loop_s1a", gpio_out, 32'h22);
      tick();
      check("loop_s1b", gpio_out, 32'h22);
      check("loop_done", {31'b0, done}, {31'b0, r == 3});
      tick();
    end
    check("loop_end_gpio", gpio_out, 32'h0);
    check("loop_end_busy", {31'b0, busy}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
